comp_alu_pipe: RTL and testbench

//  Pipelined, parametrised successor to the combinational RF+ALU composite.

---
 rtl/comp_alu_pipe.sv | 221 ++++++++++++++++++++++
 tb/tb_comp_alu_pipe.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comp_alu_pipe.sv
// Two-stage pipelined R-type ALU with an internal 32-entry register file, operand forwarding and valid/ready output.
// Optional signed-overflow output is enabled by defining COMPALU_OVF_EN.
`timescale 1ns/1ps
module comp_alu_pipe #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic              rf_we,
  input  logic [4:0]        rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [4:0]        out_rd,
  output logic              zero,
  output logic              carry,
  output logic              illegal
`ifdef COMPALU_OVF_EN
  ,
  output logic              overflow
`endif
);

  localparam int SHW = $clog2(DATA_W);
  localparam int MSB = DATA_W - 1;

  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;

  // Register file is a flop array: it must clear on reset and be read combinationally at accept.
  logic [DATA_W-1:0] rf_reg [NUM_REGS];

  logic              s1_valid_reg;
  logic [DATA_W-1:0] s1_a_reg;
  logic [DATA_W-1:0] s1_b_reg;
  logic [4:0]        s1_rd_reg;
  logic [4:0]        s1_sh_reg;
  logic [5:0]        s1_funct_reg;

  logic              out_valid_reg;
  logic [DATA_W-1:0] result_reg;
  logic [4:0]        out_rd_reg;
  logic              zero_reg;
  logic              carry_reg;
  logic              illegal_reg;

  logic [4:0]        dec_rs;
  logic [4:0]        dec_rt;
  logic [4:0]        dec_rd;
  logic [4:0]        dec_sh;
  logic [5:0]        dec_funct;
  logic              unused_opcode;

  logic              s2_free;
  logic              s1_adv;
  logic              accept;
  logic              wb_en;

  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   diff_ext;
  logic [5:0]        sh_ext;
  logic [SHW-1:0]    sh_amt;
  logic [DATA_W-1:0] ex_result;
  logic              ex_carry;
  logic              ex_illegal;

  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [NUM_REGS-1:0] wb_hit;
  logic [NUM_REGS-1:0] host_hit;

  assign dec_rs        = instr[25:21];
  assign dec_rt        = instr[20:16];
  assign dec_rd        = instr[15:11];
  assign dec_sh        = instr[10:6];
  assign dec_funct     = instr[5:0];
  assign unused_opcode = ^instr[31:26];

  assign s2_free  = !out_valid_reg || out_ready;
  assign s1_adv   = s1_valid_reg && s2_free;
  assign in_ready = (!s1_valid_reg || s1_adv) && !rf_we;
  assign accept   = in_valid && in_ready;

  // Execute stage operates on the S1 operand registers.
  assign sum_ext  = {1'b0, s1_a_reg} + {1'b0, s1_b_reg};
  assign diff_ext = {1'b0, s1_a_reg} + {1'b0, ~s1_b_reg} + {{DATA_W{1'b0}}, 1'b1};
  assign sh_ext   = {1'b0, s1_sh_reg};
  assign sh_amt   = sh_ext[SHW-1:0];

  always_comb begin
    ex_result  = '0;
    ex_carry   = 1'b0;
    ex_illegal = 1'b0;
    case (s1_funct_reg)
      F_ADD: begin
        ex_result = sum_ext[MSB:0];
        ex_carry  = sum_ext[DATA_W];
      end
      F_SUB: begin
        ex_result = diff_ext[MSB:0];
        ex_carry  = diff_ext[DATA_W];
      end
      F_AND:  ex_result = s1_a_reg & s1_b_reg;
      F_OR:   ex_result = s1_a_reg | s1_b_reg;
      F_XOR:  ex_result = s1_a_reg ^ s1_b_reg;
      F_NOR:  ex_result = ~(s1_a_reg | s1_b_reg);
      F_SLT:  ex_result = {{(DATA_W-1){1'b0}}, ($signed(s1_a_reg) < $signed(s1_b_reg))};
      F_SLTU: ex_result = {{(DATA_W-1){1'b0}}, (s1_a_reg < s1_b_reg)};
      F_SLL:  ex_result = s1_b_reg << sh_amt;
      F_SRL:  ex_result = s1_b_reg >> sh_amt;
      F_SRA:  ex_result = $signed(s1_b_reg) >>> sh_amt;
      default: ex_illegal = 1'b1;
    endcase
  end

  // Writeback happens as the instruction leaves S1; the same value is forwarded to a concurrent accept.
  assign wb_en  = s1_adv && (s1_rd_reg != 5'd0) && !ex_illegal;
  assign rs_val = (wb_en && (dec_rs == s1_rd_reg)) ? ex_result : rf_reg[dec_rs];
  assign rt_val = (wb_en && (dec_rt == s1_rd_reg)) ? ex_result : rf_reg[dec_rt];

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rf_sel
      assign wb_hit[gi]   = wb_en && (s1_rd_reg == 5'(gi));
      assign host_hit[gi] = rf_we && (rf_waddr == 5'(gi)) && (gi != 0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wb_hit[i])        rf_reg[i] <= ex_result;
        else if (host_hit[i]) rf_reg[i] <= rf_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_rd_reg    <= '0;
      s1_sh_reg    <= '0;
      s1_funct_reg <= '0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      s1_a_reg     <= rs_val;
      s1_b_reg     <= rt_val;
      s1_rd_reg    <= dec_rd;
      s1_sh_reg    <= dec_sh;
      s1_funct_reg <= dec_funct;
    end else if (s1_adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      out_rd_reg    <= '0;
      zero_reg      <= 1'b1;
      carry_reg     <= 1'b0;
      illegal_reg   <= 1'b0;
    end else if (s2_free) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        result_reg  <= ex_result;
        out_rd_reg  <= s1_rd_reg;
        zero_reg    <= (ex_result == '0);
        carry_reg   <= ex_carry;
        illegal_reg <= ex_illegal;
      end
    end
  end

`ifdef COMPALU_OVF_EN
  logic ex_ovf;
  logic overflow_reg;

  always_comb begin
    ex_ovf = 1'b0;
    case (s1_funct_reg)
      F_ADD:   ex_ovf = (s1_a_reg[MSB] == s1_b_reg[MSB]) && (sum_ext[MSB] != s1_a_reg[MSB]);
      F_SUB:   ex_ovf = (s1_a_reg[MSB] != s1_b_reg[MSB]) && (diff_ext[MSB] != s1_a_reg[MSB]);
      default: ex_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                        overflow_reg <= 1'b0;
    else if (s2_free && s1_valid_reg)  overflow_reg <= ex_ovf;
  end

  assign overflow = overflow_reg;
`endif

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign out_rd    = out_rd_reg;
  assign zero      = zero_reg;
  assign carry     = carry_reg;
  assign illegal   = illegal_reg;

endmodule

// File: tb/tb_comp_alu_pipe.sv
// Scoreboard bench for comp_alu_pipe: an in-order ISA model predicts each result at accept time,
// a negedge monitor pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_comp_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, rf_we, out_valid, out_ready;
  logic [31:0] instr, rf_wdata, result;
  logic [4:0]  rf_waddr, out_rd;
  logic        zero, carry, illegal;

  always #5 clk = ~clk;

  comp_alu_pipe #(.DATA_W(32), .NUM_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_rd(out_rd),
    .zero(zero), .carry(carry), .illegal(illegal)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        z;
    logic        c;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_rf [32];
  int          checks = 0;
  int          errors = 0;
  int          txn = 0;
  bit          rand_rdy = 0;

  // Architectural (program-order) semantics of one instruction.
  function automatic exp_t ref_exec(input logic [31:0] ins);
    exp_t        e;
    logic [31:0] a, b, r;
    logic [32:0] s;
    logic [4:0]  sh;
    logic        c, ill;
    a = model_rf[ins[25:21]];
    b = model_rf[ins[20:16]];
    sh = ins[10:6];
    r = 32'd0; c = 1'b0; ill = 1'b0;
    case (ins[5:0])
      6'h20: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
      6'h22: begin r = a - b; c = (a >= b); end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h2B: r = (a < b) ? 32'd1 : 32'd0;
      6'h00: r = b << sh;
      6'h02: r = b >> sh;
      6'h03: r = $signed(b) >>> sh;
      default: ill = 1'b1;
    endcase
    e.res = r; e.rd = ins[15:11]; e.z = (r == 32'd0); e.c = c; e.ill = ill;
    return e;
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [4:0] sh);
    logic [5:0] junk;
    junk = 6'($urandom);
    return {junk, rs, rt, rd, sh, f};
  endfunction

  function automatic logic [5:0] pick_funct(input int idx);
    case (idx)
      0: return 6'h20;  1: return 6'h22;  2: return 6'h24;  3: return 6'h25;
      4: return 6'h26;  5: return 6'h27;  6: return 6'h2A;  7: return 6'h2B;
      8: return 6'h00;  9: return 6'h02;  10: return 6'h03;
      default: return 6'h3F;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Holds the instruction until accepted; returns just after the accepting edge.
  task automatic issue(input logic [31:0] ins, output int waits);
    exp_t e;
    waits = 0;
    in_valid = 1'b1;
    instr = ins;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 300) begin
        checks++; errors++;
        $display("FAIL issue_timeout instr %h not accepted within 300 cycles", ins);
        in_valid = 1'b0;
        return;
      end
    end
    e = ref_exec(ins);
    sb.push_back(e);
    if (!e.ill && e.rd != 5'd0) model_rf[e.rd] = e.res;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic rf_load(input logic [4:0] addr, input logic [31:0] data);
    rf_we = 1'b1; rf_waddr = addr; rf_wdata = data;
    @(posedge clk); #1;
    rf_we = 1'b0;
    if (addr != 5'd0) model_rf[addr] = data;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk); n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: a handshake seen at the negedge completes at the following posedge.
  initial begin
    exp_t e, act;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        txn++;
        act = {result, out_rd, zero, carry, illegal};
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output res=%h rd=%0d with empty scoreboard", result, out_rd);
        end else begin
          e = sb.pop_front();
          $display("txn %0d rd=%0d res=%h z=%b c=%b ill=%b", txn, out_rd, result, zero, carry, illegal);
          if (act !== e)
            $display("FAIL txn%0d got res=%h rd=%0d z=%b c=%b ill=%b want res=%h rd=%0d z=%b c=%b ill=%b",
                     txn, result, out_rd, zero, carry, illegal, e.res, e.rd, e.z, e.c, e.ill);
          if (act !== e) errors++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 9) < 7);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, w2;
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0; out_ready = 1'b0;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_out_rd", {27'd0, out_rd}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_carry", {31'd0, carry}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Basic ADD and two-cycle latency
    out_ready = 1'b1;
    rf_load(5'd1, 32'd5);
    rf_load(5'd2, 32'd3);
    issue(mk(6'h20, 5'd1, 5'd2, 5'd3, 5'd0), w);
    @(negedge clk);
    check("latency_edge1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("latency_edge2", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    issue(mk(6'h20, 5'd3, 5'd0, 5'd10, 5'd0), w);
    drain();

    // Carry and zero on wrap, SUB equal operands
    rf_load(5'd1, 32'hFFFF_FFFF);
    rf_load(5'd2, 32'd1);
    issue(mk(6'h20, 5'd1, 5'd2, 5'd3, 5'd0), w);
    issue(mk(6'h22, 5'd2, 5'd2, 5'd4, 5'd0), w);
    drain();

    // Forwarding with no bubble
    rf_load(5'd1, 32'd5);
    rf_load(5'd2, 32'd3);
    issue(mk(6'h20, 5'd1, 5'd2, 5'd3, 5'd0), w);
    issue(mk(6'h20, 5'd3, 5'd3, 5'd5, 5'd0), w2);
    check("no_bubble_waits", w2, 32'd0);
    issue(mk(6'h20, 5'd5, 5'd0, 5'd12, 5'd0), w);
    drain();

    // Shifts and compares
    rf_load(5'd1, 32'h8000_0000);
    rf_load(5'd2, 32'hFFFF_FFFF);
    rf_load(5'd3, 32'd1);
    issue(mk(6'h03, 5'd0, 5'd1, 5'd6, 5'd4), w);
    issue(mk(6'h2A, 5'd2, 5'd3, 5'd7, 5'd0), w);
    issue(mk(6'h2B, 5'd2, 5'd3, 5'd8, 5'd0), w);
    issue(mk(6'h00, 5'd0, 5'd3, 5'd9, 5'd31), w);
    issue(mk(6'h02, 5'd0, 5'd1, 5'd9, 5'd31), w);
    drain();

    // Illegal funct leaves rd untouched
    issue(mk(6'h3F, 5'd1, 5'd2, 5'd3, 5'd0), w);
    issue(mk(6'h20, 5'd3, 5'd0, 5'd11, 5'd0), w);
    drain();

    // Backpressure: two held, third waits, outputs stable
    out_ready = 1'b0;
    rf_load(5'd1, 32'd100);
    issue(mk(6'h20, 5'd1, 5'd1, 5'd13, 5'd0), w);
    issue(mk(6'h20, 5'd13, 5'd1, 5'd14, 5'd0), w);
    fork
      issue(mk(6'h22, 5'd14, 5'd13, 5'd15, 5'd0), w);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_in_ready", {31'd0, in_ready}, 32'd0);
          check("bp_out_valid", {31'd0, out_valid}, 32'd1);
          check("bp_result_hold", result, sb[0].res);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Host load and writeback to r7 on the same edge
    rf_load(5'd1, 32'd4);
    rf_load(5'd2, 32'd9);
    issue(mk(6'h20, 5'd1, 5'd2, 5'd7, 5'd0), w);
    rf_we = 1'b1; rf_waddr = 5'd7; rf_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rf_we = 1'b0;
    issue(mk(6'h20, 5'd7, 5'd0, 5'd8, 5'd0), w);
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    issue(mk(6'h20, 5'd1, 5'd2, 5'd16, 5'd0), w);
    issue(mk(6'h20, 5'd1, 5'd1, 5'd17, 5'd0), w);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(mk(6'h20, 5'd1, 5'd2, 5'd9, 5'd0), w);
    issue(mk(6'h25, 5'd16, 5'd17, 5'd10, 5'd0), w);
    drain();

    // Randomised traffic with random sink stalls
    for (int i = 1; i < 32; i++) rf_load(5'(i), $urandom);
    rand_rdy = 1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        drain();
        rf_load(5'($urandom), $urandom);
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
        issue(mk(pick_funct($urandom_range(0, 11)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom)), w);
      end
    end
    drain();
    rand_rdy = 0;
    out_ready = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
